// File: rtl/affine_had_satd_accum.sv
// 4x4 Hadamard SATD accumulator feeding affine_control: one residual row per beat,
// first pass summed into had_4_param, second pass into had_6_param, both saturating.
module affine_had_satd_accum #(
    parameter int RES_W = 10,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         num_of_sub_blk,
    input  logic               res_valid,
    input  logic [4*RES_W-1:0] res_row,
    output logic               res_ready,
    output logic [ACC_W-1:0]   had_4_param,
    output logic [ACC_W-1:0]   had_6_param,
    output logic               had_valid,
    output logic               busy
);

    localparam int RW = RES_W + 2;                          // row transform width
    localparam int CW = RES_W + 4;                          // column transform width
    localparam int SW = RES_W + 8;                          // sum of |coef| width
    localparam int AW = ((ACC_W > SW) ? ACC_W : SW) + 1;    // accumulator headroom

    typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

    state_t               state, state_nxt;
    logic signed [RW-1:0] row_buf [4][4];
    logic [1:0]           row_cnt;
    logic [5:0]           blk_cnt;
    logic [5:0]           n_reg;
    logic                 pass;

    logic signed [RES_W-1:0] s [4];
    logic signed [RW-1:0]    t [4];
    logic signed [CW-1:0]    c [4];
    logic [SW-1:0]           abs_sum;
    logic [SW-1:0]           satd;
    logic [ACC_W-1:0]        acc_sel;
    logic [AW-1:0]           acc_sum;
    logic [ACC_W-1:0]        acc_sat;
    logic                    row_fire;
    logic                    blk_last;

    function automatic logic [CW-1:0] mag(input logic signed [CW-1:0] v);
        return v[CW-1] ? CW'(-v) : CW'(v);
    endfunction

    assign row_fire = (state == ROW) && res_valid;
    assign blk_last = (blk_cnt + 6'd1) == n_reg;

    // Row butterfly on the incoming beat
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            s[j] = res_row[j*RES_W +: RES_W];
        end
        t[0] = RW'(s[0]) + RW'(s[1]) + RW'(s[2]) + RW'(s[3]);
        t[1] = RW'(s[0]) - RW'(s[1]) + RW'(s[2]) - RW'(s[3]);
        t[2] = RW'(s[0]) + RW'(s[1]) - RW'(s[2]) - RW'(s[3]);
        t[3] = RW'(s[0]) - RW'(s[1]) - RW'(s[2]) + RW'(s[3]);
    end

    // Column butterfly over the buffered rows, then sum of magnitudes
    // NOTE: every variable written here gets a value before any branch or loop, so no latch is inferred.
    always_comb begin
        abs_sum = '0;
        c       = '{default: '0};
        for (int j = 0; j < 4; j++) begin
            c[0] = CW'(row_buf[0][j]) + CW'(row_buf[1][j]) + CW'(row_buf[2][j]) + CW'(row_buf[3][j]);
            c[1] = CW'(row_buf[0][j]) - CW'(row_buf[1][j]) + CW'(row_buf[2][j]) - CW'(row_buf[3][j]);
            c[2] = CW'(row_buf[0][j]) + CW'(row_buf[1][j]) - CW'(row_buf[2][j]) - CW'(row_buf[3][j]);
            c[3] = CW'(row_buf[0][j]) - CW'(row_buf[1][j]) - CW'(row_buf[2][j]) + CW'(row_buf[3][j]);
            for (int m = 0; m < 4; m++) begin
                abs_sum = abs_sum + SW'(mag(c[m]));
            end
        end
        satd    = (abs_sum + SW'(1)) >> 1;
        acc_sel = pass ? had_6_param : had_4_param;
        acc_sum = AW'(acc_sel) + AW'(satd);
        acc_sat = (|acc_sum[AW-1:ACC_W]) ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        res_ready = 1'b0;
        had_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_of_sub_blk == 6'd0) ? DONE : ROW;
                end
            end
            ROW: begin
                res_ready = 1'b1;
                if (res_valid && (row_cnt == 2'd3)) begin
                    state_nxt = COL;
                end
            end
            COL: begin
                state_nxt = (blk_last && pass) ? DONE : ROW;
            end
            DONE: begin
                had_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the row buffer is a small register array, so it joins the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf     <= '{default: '{default: '0}};
            row_cnt     <= '0;
            blk_cnt     <= '0;
            n_reg       <= '0;
            pass        <= 1'b0;
            had_4_param <= '0;
            had_6_param <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                row_cnt     <= '0;
                blk_cnt     <= '0;
                pass        <= 1'b0;
                n_reg       <= num_of_sub_blk;
                had_4_param <= '0;
                had_6_param <= '0;
            end
            if (row_fire) begin
                for (int k = 0; k < 4; k++) begin
                    row_buf[row_cnt][k] <= t[k];
                end
                row_cnt <= row_cnt + 2'd1;
            end
            if (state == COL) begin
                if (pass) begin
                    had_6_param <= acc_sat;
                end else begin
                    had_4_param <= acc_sat;
                end
                // Pass boundary restarts the block count for the 6-parameter sweep
                if (blk_last && !pass) begin
                    pass    <= 1'b1;
                    blk_cnt <= '0;
                end else begin
                    blk_cnt <= blk_cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_affine_had_satd_accum.sv
// Directed bench for affine_had_satd_accum: DC, impulse, saturation, random handshake,
// empty job and mid-run reset, each checked against hand-computed or independently modelled sums.
module tb_affine_had_satd_accum;

    localparam int RES_W = 10;
    localparam int ACC_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [5:0]         num_of_sub_blk = '0;
    logic               res_valid = 1'b0;
    logic [4*RES_W-1:0] res_row = '0;
    logic               res_ready;
    logic [ACC_W-1:0]   had_4_param;
    logic [ACC_W-1:0]   had_6_param;
    logic               had_valid;
    logic               busy;

    affine_had_satd_accum #(.RES_W(RES_W), .ACC_W(ACC_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_of_sub_blk (num_of_sub_blk),
        .res_valid      (res_valid),
        .res_row        (res_row),
        .res_ready      (res_ready),
        .had_4_param    (had_4_param),
        .had_6_param    (had_6_param),
        .had_valid      (had_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hv_count = 0;
    int hv_cyc = -1;
    int rows_acc = 0;
    int ready_cnt = 0;
    int start_cyc = 0;
    int blk [4][4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (had_valid) begin
            hv_count = hv_count + 1;
            hv_cyc   = cyc;
        end
    end

    always @(posedge clk) begin
        if (res_valid && res_ready) rows_acc = rows_acc + 1;
        if (res_ready) ready_cnt = ready_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Independent reference: Y = H*X*H as an explicit matrix product
    function automatic int model_satd();
        int h [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};
        int tmp [4][4];
        int acc = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tmp[i][j] = 0;
                for (int k = 0; k < 4; k++) tmp[i][j] += h[i][k] * blk[k][j];
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int y = 0;
                for (int k = 0; k < 4; k++) y += tmp[i][k] * h[k][j];
                acc += (y < 0) ? -y : y;
            end
        return (acc + 1) >> 1;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) blk[i][j] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) blk[i][j] = int'($urandom_range(0, 1022)) - 511;
    endtask

    task automatic do_start(input int n);
        num_of_sub_blk = 6'(n);
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_row(input int i, input bit rand_gap, input bit noise);
        bit ok = 1'b0;
        int v;
        if (rand_gap) begin
            repeat ($urandom_range(0, 2)) begin
                res_valid = 1'b0;
                res_row   = {$urandom, $urandom};
                start     = noise && ($urandom_range(0, 3) == 0);
                @(posedge clk); #1;
            end
        end
        res_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            v = blk[i][j];
            res_row[j*RES_W +: RES_W] = v[RES_W-1:0];
        end
        for (int k = 0; k < 50 && !ok; k++) begin
            ok    = res_ready;
            start = noise && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!ok) check("row_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_block(input bit rand_gap, input bit noise);
        for (int i = 0; i < 4; i++) send_row(i, rand_gap, noise);
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        res_valid = 1'b0;
        while (hv_count == base && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (hv_count == base) check("had_valid_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base, rows0, rdy0, e4, e6;

        // Reset state
        #12;
        check("rst_had4", 32'(had_4_param), 32'd0);
        check("rst_had6", 32'(had_6_param), 32'd0);
        check("rst_valid", 32'(had_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(res_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: N=1 DC of +1, latency from start to had_valid
        base = hv_count; rows0 = rows_acc;
        fill_const(1);
        do_start(1);
        send_block(1'b0, 1'b0);
        send_block(1'b0, 1'b0);
        wait_done(base);
        check("t1_latency", 32'(hv_cyc - start_cyc), 32'd11);
        check("t1_had4", 32'(had_4_param), 32'd8);
        check("t1_had6", 32'(had_6_param), 32'd8);
        check("t1_valid_once", 32'(hv_count - base), 32'd1);
        check("t1_rows", 32'(rows_acc - rows0), 32'd8);

        // 2: N=2 impulse, start pulsed across the COL/DONE cycles
        base = hv_count;
        fill_const(0);
        blk[0][0] = 1;
        do_start(2);
        repeat (3) send_block(1'b0, 1'b0);
        send_row(0, 1'b0, 1'b0);
        send_row(1, 1'b0, 1'b0);
        send_row(2, 1'b0, 1'b0);
        send_row(3, 1'b0, 1'b0);
        res_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t2_busy_after_done_start", 32'(busy), 32'd0);
        wait_done(base);
        check("t2_had4", 32'(had_4_param), 32'd16);
        check("t2_had6", 32'(had_6_param), 32'd16);
        check("t2_valid_once", 32'(hv_count - base), 32'd1);

        // 3: N=63 all +511, sticky saturation
        base = hv_count;
        fill_const(511);
        do_start(63);
        repeat (126) send_block(1'b0, 1'b0);
        wait_done(base);
        check("t3_had4_sat", 32'(had_4_param), 32'hFFFF);
        check("t3_had6_sat", 32'(had_6_param), 32'hFFFF);

        // 4: N=3 random residuals, valid gaps, start noise while busy
        base = hv_count; rows0 = rows_acc;
        e4 = 0; e6 = 0;
        do_start(3);
        for (int b = 0; b < 6; b++) begin
            fill_random();
            if (b < 3) e4 = sat_add(e4, model_satd());
            else       e6 = sat_add(e6, model_satd());
            send_block(1'b1, 1'b1);
        end
        wait_done(base);
        check("t4_had4", 32'(had_4_param), 32'(e4));
        check("t4_had6", 32'(had_6_param), 32'(e6));
        check("t4_rows", 32'(rows_acc - rows0), 32'd24);
        check("t4_valid_once", 32'(hv_count - base), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);

        // 5: N=0 finishes immediately with zero sums
        base = hv_count; rdy0 = ready_cnt;
        do_start(0);
        wait_done(base);
        check("t5_latency", 32'(hv_cyc - start_cyc), 32'd1);
        check("t5_had4", 32'(had_4_param), 32'd0);
        check("t5_had6", 32'(had_6_param), 32'd0);
        check("t5_no_ready", 32'(ready_cnt - rdy0), 32'd0);

        // 6: reset during second pass of N=4, then a clean N=1 job
        base = hv_count;
        fill_const(1);
        do_start(4);
        repeat (5) send_block(1'b0, 1'b0);
        send_row(0, 1'b0, 1'b0);
        res_valid = 1'b0;
        check("t6_pass1_had4", 32'(had_4_param), 32'd32);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_had4", 32'(had_4_param), 32'd0);
        check("t6_rst_had6", 32'(had_6_param), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ready", 32'(res_ready), 32'd0);
        check("t6_rst_valid", 32'(had_valid), 32'd0);
        check("t6_no_done", 32'(hv_count - base), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = hv_count;
        fill_const(0);
        blk[0][0] = 1;
        do_start(1);
        send_block(1'b0, 1'b0);
        send_block(1'b0, 1'b0);
        wait_done(base);
        check("t6_fresh_had4", 32'(had_4_param), 32'd8);
        check("t6_fresh_had6", 32'(had_6_param), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
